// File: rtl/stepdir_generator.sv
// stepdir_generator: step/dir motion front-end for microstepper_top.
// Takes move commands (direction, step count, step period) over a
// valid/ready handshake and emits timed step pulses. dir only ever changes
// in the cycle after an accept. It is never changed while step is high or
// between pulses of a move.
// Optional feature macro: STEPDIR_POSITION_EN adds a signed position counter
// (port 'position'). When the macro is undefined, the port and the counter
// are both absent.
module stepdir_generator #(
    parameter int COUNT_W  = 16,
    parameter int PERIOD_W = 24
`ifdef STEPDIR_POSITION_EN
    ,
    parameter int POS_W    = 32
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_dir,
    input  logic [COUNT_W-1:0]  cmd_steps,
    input  logic [PERIOD_W-1:0] cmd_period,
    input  logic [7:0]          config_pulse_width,
    input  logic [7:0]          config_dir_setup,
    input  logic                abort,
    output logic                step,
    output logic                dir,
    output logic                busy,
    output logic                done,
    output logic [COUNT_W-1:0]  steps_remaining
`ifdef STEPDIR_POSITION_EN
    ,
    output logic signed [POS_W-1:0] position
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_HIGH   = 3'd2,
        ST_LOW    = 3'd3,
        ST_FINISH = 3'd4
    } state_e;

    // A configured value of 0 is treated as 1.
    function automatic logic [7:0] clamp_min1(input logic [7:0] v);
        clamp_min1 = (v == 8'd0) ? 8'd1 : v;
    endfunction

    state_e               state_q, state_d;
    logic [PERIOD_W-1:0]  cnt_q, cnt_d;
    logic [COUNT_W-1:0]   rem_q, rem_d;
    logic                 dir_q, dir_d;
    logic [PERIOD_W-1:0]  pw_last_q, pw_last_d;
    logic [PERIOD_W-1:0]  per_last_q, per_last_d;
    logic [PERIOD_W-1:0]  setup_last_q, setup_last_d;
    logic                 abort_pend_q, abort_pend_d;
    logic                 step_q, busy_q, done_q;

    logic                 cmd_ready_s;
    logic                 accept_s;
    logic [PERIOD_W-1:0]  pw_ext_s;
    logic [PERIOD_W-1:0]  per_s;

    // The FINISH cycle also accepts, so back-to-back moves lose no cycle.
    assign cmd_ready_s = ((state_q == ST_IDLE) || (state_q == ST_FINISH)) && !reset;
    assign accept_s    = cmd_valid && cmd_ready_s;

    // Effective timing. The period is stretched so that at least one low cycle follows each pulse.
    assign pw_ext_s = PERIOD_W'(clamp_min1(config_pulse_width));
    assign per_s    = (cmd_period > pw_ext_s) ? cmd_period : (pw_ext_s + PERIOD_W'(1));

    // Next-state logic for the move sequencer, phase counter and latched move parameters.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rem_d        = rem_q;
        dir_d        = dir_q;
        pw_last_d    = pw_last_q;
        per_last_d   = per_last_q;
        setup_last_d = setup_last_q;
        abort_pend_d = abort_pend_q;
        case (state_q)
            ST_IDLE, ST_FINISH: begin
                abort_pend_d = 1'b0;
                if (accept_s) begin
                    pw_last_d    = pw_ext_s - PERIOD_W'(1);
                    per_last_d   = per_s - PERIOD_W'(1);
                    setup_last_d = PERIOD_W'(clamp_min1(config_dir_setup)) - PERIOD_W'(1);
                    rem_d        = cmd_steps;
                    cnt_d        = '0;
                    if (cmd_steps == '0) begin
                        state_d = ST_FINISH;
                    end else if (cmd_dir != dir_q) begin
                        dir_d   = cmd_dir;
                        state_d = ST_SETUP;
                    end else begin
                        state_d = ST_HIGH;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (abort) begin
                    state_d = ST_FINISH;
                end else if (cnt_q == setup_last_q) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + PERIOD_W'(1);
                end
            end
            ST_HIGH: begin
                // An abort during the pulse is remembered. The pulse still completes, so no runt pulse is emitted.
                abort_pend_d = abort_pend_q | abort;
                cnt_d        = cnt_q + PERIOD_W'(1);
                if (cnt_q == pw_last_q) begin
                    state_d = ST_LOW;
                    rem_d   = rem_q - COUNT_W'(1);
                end else begin
                    state_d = ST_HIGH;
                end
            end
            ST_LOW: begin
                if (abort || abort_pend_q || (rem_q == '0)) begin
                    state_d = ST_FINISH;
                end else if (cnt_q == per_last_q) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + PERIOD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, plus the outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            rem_q        <= '0;
            dir_q        <= 1'b0;
            pw_last_q    <= '0;
            per_last_q   <= '0;
            setup_last_q <= '0;
            abort_pend_q <= 1'b0;
            step_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rem_q        <= rem_d;
            dir_q        <= dir_d;
            pw_last_q    <= pw_last_d;
            per_last_q   <= per_last_d;
            setup_last_q <= setup_last_d;
            abort_pend_q <= abort_pend_d;
            step_q       <= (state_d == ST_HIGH);
            busy_q       <= (state_d == ST_SETUP) || (state_d == ST_HIGH) || (state_d == ST_LOW);
            done_q       <= (state_d == ST_FINISH);
        end
    end

    assign cmd_ready       = cmd_ready_s;
    assign step            = step_q;
    assign dir             = dir_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign steps_remaining = rem_q;

`ifdef STEPDIR_POSITION_EN
    logic signed [POS_W-1:0] pos_q;

    // Signed position, moved one count on each step rise in the direction being driven.
    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q <= '0;
        end else if ((state_d == ST_HIGH) && (state_q != ST_HIGH)) begin
            pos_q <= dir_d ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));
        end else begin
            pos_q <= pos_q;
        end
    end

    assign position = pos_q;
`endif

endmodule
